// File: rtl/stack_client.sv
// Stack controller: the top-of-stack lives in a register, deeper entries in an
// external pointer-based RAM. A RAM-moving command is followed by one SETTLE cycle.
module stack_client #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  output logic                       rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [WIDTH-1:0]           tos,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err_overflow,
  output logic                       err_underflow,
  input  logic                       err_clr,
  output logic                       stk_we,
  output logic [1:0]                 stk_delta,
  output logic [WIDTH-1:0]           stk_wd,
  input  logic [WIDTH-1:0]           stk_rd
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic {IDLE, SETTLE} state_t;
  state_t state;

  logic accept, has_two, ram_push, ram_pop, ovf_set, unf_set;

  assign cmd_ready = (state == IDLE);
  // Gate with rst_n so no RAM strobe escapes while reset is held with cmd_valid high.
  assign accept    = rst_n && cmd_valid && cmd_ready;
  assign empty     = (depth == '0);
  assign full      = (depth == DEPTH_MAX);
  assign has_two   = (depth >= DW'(2));

  assign ram_push  = accept && (cmd_op == OP_PUSH) && !empty && !full;
  assign ram_pop   = accept && (cmd_op == OP_POP) && has_two;
  assign stk_we    = ram_push;
  assign stk_delta = ram_push ? 2'b01 : (ram_pop ? 2'b11 : 2'b00);
  assign stk_wd    = tos;

  assign ovf_set   = accept && (cmd_op == OP_PUSH) && full;
  assign unf_set   = accept && ((cmd_op == OP_POP) || (cmd_op == OP_REPL)) && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tos           <= '0;
      depth         <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      state     <= IDLE;
      if (accept) begin
        case (cmd_op)
          OP_PUSH: begin
            if (!full) begin
              tos   <= cmd_data;
              depth <= depth + DW'(1);
              if (!empty) state <= SETTLE;
            end
          end
          OP_POP: begin
            rsp_valid <= 1'b1;
            if (empty) begin
              rsp_data <= '0;
            end else begin
              rsp_data <= tos;
              depth    <= depth - DW'(1);
              if (has_two) begin
                tos   <= stk_rd;
                state <= SETTLE;
              end else begin
                tos <= '0;
              end
            end
          end
          OP_REPL: if (!empty) tos <= cmd_data;
          default: ;
        endcase
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      err_overflow  <= ovf_set | (err_overflow & ~err_clr);
      err_underflow <= unf_set | (err_underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_stack_client.sv
// Randomized bench for stack_client: queue-based stack model plus a queue-backed
// stand-in for the external stack RAM.
module tb_stack_client;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH) + 1;
  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;

  logic             clk = 0, rst_n = 0;
  logic             cmd_valid = 0, cmd_ready, err_clr = 0;
  logic [1:0]       cmd_op = NOP;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             rsp_valid, empty, full, err_overflow, err_underflow, stk_we;
  logic [WIDTH-1:0] rsp_data, tos, stk_wd, stk_rd;
  logic [DW-1:0]    depth;
  logic [1:0]       stk_delta;

  stack_client #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tos(tos), .depth(depth), .empty(empty), .full(full),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr),
    .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd));

  always #5 clk = ~clk;

  // External stack RAM: NOS is registered, so it is valid the cycle after a move.
  logic [WIDTH-1:0] ram_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q.delete();
      stk_rd <= '0;
    end else begin
      if (stk_we && stk_delta == 2'b01) ram_q.push_back(stk_wd);
      else if (stk_delta == 2'b11 && ram_q.size() > 0) void'(ram_q.pop_back());
      stk_rd <= (ram_q.size() > 0) ? ram_q[$] : '0;
    end
  end

  // Reference model
  logic [WIDTH-1:0] ref_q[$];
  logic [WIDTH-1:0] exp_rsp = '0;
  bit exp_ovf = 0, exp_unf = 0;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_state(input bit exp_rv);
    int n = ref_q.size();
    chk("tos", tos, (n > 0) ? ref_q[n-1] : '0);
    chk("depth", depth, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_data", rsp_data, exp_rsp);
    chk("err_overflow", err_overflow, exp_ovf);
    chk("err_underflow", err_underflow, exp_unf);
  endtask

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d, input bit clr);
    int n = ref_q.size();
    logic [WIDTH-1:0] top = (n > 0) ? ref_q[n-1] : '0;
    bit exp_we = (op == PUSH) && n >= 1 && n < DEPTH;
    logic [1:0] exp_dl = exp_we ? 2'b01 : ((op == POP && n >= 2) ? 2'b11 : 2'b00);
    bit set_o = 0, set_u = 0, rv = 0;
    cmd_valid = 1; cmd_op = op; cmd_data = d; err_clr = clr;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    chk("stk_we", stk_we, exp_we);
    chk("stk_delta", stk_delta, exp_dl);
    if (exp_we) chk("stk_wd", stk_wd, top);
    @(posedge clk);
    case (op)
      PUSH: if (n == DEPTH) set_o = 1; else ref_q.push_back(d);
      POP: begin
        rv = 1;
        if (n == 0) begin set_u = 1; exp_rsp = '0; end
        else exp_rsp = ref_q.pop_back();
      end
      REPL: if (n == 0) set_u = 1; else ref_q[n-1] = d;
      default: ;
    endcase
    exp_ovf = set_o || (exp_ovf && !clr);
    exp_unf = set_u || (exp_unf && !clr);
    #1;
    check_state(rv);
    chk("ready_after", cmd_ready, exp_dl == 2'b00);
    @(negedge clk);
    cmd_valid = 0; err_clr = 0;
    if (exp_dl != 2'b00) begin
      // A command offered during SETTLE must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom); cmd_data = WIDTH'($urandom);
      #1;
      chk("settle_we", stk_we, 0);
      chk("settle_delta", stk_delta, 0);
      @(posedge clk); #1;
      check_state(0);
      chk("settle_done", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 0;
    end
  endtask

  task automatic reset_model();
    ref_q.delete(); exp_rsp = '0; exp_ovf = 0; exp_unf = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_tos", tos, 0);
    chk("rst_depth", depth, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_unf", err_underflow, 0);
    chk("rst_we", stk_we, 0);
    chk("rst_delta", stk_delta, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_empty", empty, 1);
  endtask

  initial begin
    int r;
    // Reset with a command pending: nothing may be accepted.
    cmd_valid = 1; cmd_op = PUSH; cmd_data = 16'hdead;
    #3 check_reset_outputs();
    @(negedge clk); @(negedge clk);
    cmd_valid = 0; rst_n = 1;
    reset_model();
    @(posedge clk); #1 check_state(0);
    @(negedge clk);

    // Push three, pop three
    issue(PUSH, 16'h1111, 0);
    issue(PUSH, 16'h2222, 0);
    issue(PUSH, 16'h3333, 0);
    chk("push3_tos", tos, 16'h3333);
    issue(POP, 0, 0); chk("pop1", rsp_data, 16'h3333);
    issue(POP, 0, 0); chk("pop2", rsp_data, 16'h2222);
    issue(POP, 0, 0); chk("pop3", rsp_data, 16'h1111);
    chk("pop3_empty", empty, 1);

    // Underflow, then clear; set-with-clear keeps the flag.
    issue(POP, 0, 0);
    chk("unf_set", err_underflow, 1);
    issue(NOP, 0, 1);
    chk("unf_clr", err_underflow, 0);
    issue(REPL, 16'h7777, 1);
    chk("unf_set_wins", err_underflow, 1);
    issue(NOP, 0, 1);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) issue(PUSH, WIDTH'($urandom), 0);
    chk("fill_full", full, 1);
    issue(PUSH, 16'hbeef, 0);
    chk("ovf_set", err_overflow, 1);
    chk("ovf_depth", depth, DEPTH);
    issue(NOP, 0, 1);
    for (int i = 0; i < DEPTH; i++) issue(POP, 0, 0);

    // Single-entry traffic stays off the RAM.
    issue(PUSH, 16'h0005, 0);
    issue(REPL, 16'h0009, 0);
    issue(POP, 0, 0);
    chk("repl_pop", rsp_data, 16'h0009);

    // Randomized traffic with occasional idle gaps.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      issue((r < 45) ? PUSH : (r < 80) ? POP : (r < 92) ? REPL : NOP,
            WIDTH'($urandom), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1 check_state(0);
        @(negedge clk);
      end
    end

    // Reset in the middle of SETTLE.
    if (ref_q.size() == 0) issue(PUSH, 16'h00aa, 0);
    if (ref_q.size() == DEPTH) issue(POP, 0, 0);
    cmd_valid = 1; cmd_op = PUSH; cmd_data = 16'h4242;
    @(posedge clk); #1;
    chk("settle_entered", cmd_ready, 0);
    rst_n = 0;
    #1 check_reset_outputs();
    reset_model();
    @(negedge clk);
    cmd_valid = 0; rst_n = 1;
    @(posedge clk); #1;
    check_state(0);
    chk("ready_post_rst", cmd_ready, 1);
    @(negedge clk);
    issue(PUSH, 16'h1234, 0);
    issue(PUSH, 16'h5678, 0);
    issue(POP, 0, 0);
    issue(POP, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stack_client.md
STACK_CLIENT -- requirements
Module: stack_client

Interface
REQ-001 Parameter: WIDTH, 16, stack data width in bits.
REQ-002 Parameter: DEPTH, 512, total capacity in entries (TOS register plus DEPTH-1 RAM entries); power of two, at least 4.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge.
REQ-007 cmd_op  in  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE.
REQ-008 cmd_data  in  WIDTH  push/replace value.
REQ-009 rsp_valid  out  1  one-cycle pulse carrying POP result.
REQ-010 rsp_data  out  WIDTH  popped value; 0 on underflow.
REQ-011 tos  out  WIDTH  registered top-of-stack.
REQ-012 depth  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-013 empty / full  out  1 each  depth==0 / depth==DEPTH, combinational from depth.
REQ-014 err_overflow / err_underflow  out  1 each  sticky error flags.
REQ-015 err_clr  in  1  synchronous clear of both sticky flags.
REQ-016 stk_we  out  1  write strobe to stack RAM.
REQ-017 stk_delta  out  2  pointer step to stack RAM: 00 hold, 01 +1, 11 -1; 10 never driven.
REQ-018 stk_wd  out  WIDTH  write data to stack RAM.
REQ-019 stk_rd  in  WIDTH  stack RAM next-on-stack (NOS), valid one cycle after last nonzero stk_delta.

Function
REQ-020 FSM states IDLE and SETTLE; cmd_ready SHALL be 1 in IDLE, 0 in SETTLE.
REQ-021 stk_we, stk_delta SHALL be combinational, nonzero only in the IDLE cycle a command is accepted; 0/00 otherwise.
REQ-022 PUSH, depth 0: tos<=cmd_data, depth<=1, no RAM access, stay IDLE.
REQ-023 PUSH, 1<=depth<DEPTH: stk_we=1, stk_delta=01, stk_wd=tos; tos<=cmd_data; depth+=1; go SETTLE.
REQ-024 PUSH, depth==DEPTH: no state change, no RAM access, err_overflow<=1, command consumed.
REQ-025 POP, depth>=2: rsp_data<=tos, rsp_valid next cycle; tos<=stk_rd; stk_delta=11; depth-=1; go SETTLE.
REQ-026 POP, depth==1: rsp_data<=tos, tos<=0, depth<=0, no RAM access, stay IDLE.
REQ-027 POP, depth 0: rsp_valid pulse with rsp_data=0, err_underflow<=1, no other change.
REQ-028 REPLACE, depth>=1: tos<=cmd_data only; REPLACE at depth 0: err_underflow<=1, no change.
REQ-029 NOP: accepted, no effect.
REQ-030 SETTLE SHALL last exactly one cycle then return to IDLE; throughput one RAM-moving command per 2 cycles, non-RAM commands 1 per cycle.
REQ-031 rsp_valid SHALL be registered: high exactly the cycle after POP acceptance, independent of cmd_valid.
REQ-032 Error set and err_clr in the same cycle: set SHALL win.
REQ-033 depth arithmetic SHALL never wrap; no RAM pointer movement beyond depth-1 entries.

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, tos=0, depth=0, rsp_valid=0, rsp_data=0, both error flags 0; stk_we=0, stk_delta=00 while asserted.
REQ-035 Reset mid-SETTLE SHALL abandon the command; the stack RAM pointer is not restored (RAM reinitialisation is the system's responsibility).

Verification
REQ-036 Reset, PUSH 0x1111,0x2222,0x3333 -> tos=0x3333, depth=3, two RAM writes of 0x1111,0x2222 with delta 01, cmd_ready low one cycle after each.
REQ-037 Then POP x3 -> rsp_data 0x3333,0x2222,0x1111 on successive pulses, final depth=0, tos=0, empty=1.
REQ-038 POP on empty -> rsp_valid with rsp_data=0, err_underflow=1; err_clr -> flag 0.
REQ-039 DEPTH pushes then one more PUSH -> full=1, err_overflow=1, tos and depth unchanged, stk_we=0.
REQ-040 PUSH 5, REPLACE 9, POP -> rsp_data=9, no RAM traffic throughout.
REQ-041 Assert rst_n low during SETTLE -> all outputs at reset values immediately, cmd_ready=1 after release.
